// File: rtl/mp64_sram_dp_be_if.sv
// rtl/mp64_sram_dp_be_if.sv - dual-port SRAM access bundle (both ports plus status)
interface mp64_sram_dp_be_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 64
);
    localparam int BE_W = DATA_W / 8;

    logic              ce_a;
    logic              we_a;
    logic [BE_W-1:0]   be_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic [DATA_W-1:0] rdata_a;
    logic              rvalid_a;

    logic              ce_b;
    logic              we_b;
    logic [BE_W-1:0]   be_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic [DATA_W-1:0] rdata_b;
    logic              rvalid_b;

    logic              init_busy;
    logic              collision;

    modport master (
        output ce_a, we_a, be_a, addr_a, wdata_a,
        output ce_b, we_b, be_b, addr_b, wdata_b,
        input  rdata_a, rvalid_a, rdata_b, rvalid_b,
        input  init_busy, collision
    );

    modport slave (
        input  ce_a, we_a, be_a, addr_a, wdata_a,
        input  ce_b, we_b, be_b, addr_b, wdata_b,
        output rdata_a, rvalid_a, rdata_b, rvalid_b,
        output init_busy, collision
    );
endinterface

// File: rtl/mp64_sram_dp_be.sv
// rtl/mp64_sram_dp_be.sv - true dual-port byte-enable SRAM with clear engine (optional MP64_SRAM_COLL_CNT_EN)
module mp64_sram_dp_be #(
    parameter int                ADDR_W         = 14,
    parameter int                DATA_W         = 64,
    parameter int                DEPTH          = 1 << ADDR_W,
    parameter int                OUT_REG        = 0,
    parameter int                RDW_MODE       = 0,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL      = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    mp64_sram_dp_be_if.slave  bus
`ifdef MP64_SRAM_COLL_CNT_EN
    ,
    output logic [15:0]       coll_count
`endif
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_DONE  = 1'b1
    } clr_state_e;

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              init_busy;
    logic              clr_we;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc_a, acc_b, wr_a, wr_b, rd_a, rd_b;
    logic              same_addr, coll_d, coll_q;
    logic [BE_W-1:0]   mask_a, mask_b;
    logic [DATA_W-1:0] old_a, old_b, post_a, post_b;
    logic [DATA_W-1:0] rdata1_a_d, rdata1_b_d;
    logic [DATA_W-1:0] rdata1_a_q, rdata1_b_q;
    logic              rvalid1_a_q, rvalid1_b_q;
    logic              upd1_a_q, upd1_b_q;

    // Clear FSM state register; reset always restarts the sweep at address 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_DONE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Clear FSM next state: sweep every word once, then park in DONE
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == S_CLEAR) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == LAST_ADDR) begin
                state_d = S_DONE;
            end
        end
    end

    // Clear FSM outputs: the sweep owns the array while busy
    always_comb begin
        init_busy = (state_q == S_CLEAR);
        clr_we    = (state_q == S_CLEAR);
    end

    // Access decode, lane arbitration (port A wins shared lanes) and read-data selection
    always_comb begin
        acc_a     = bus.ce_a & ~init_busy;
        acc_b     = bus.ce_b & ~init_busy;
        wr_a      = acc_a & bus.we_a;
        wr_b      = acc_b & bus.we_b;
        rd_a      = acc_a & ~bus.we_a;
        rd_b      = acc_b & ~bus.we_b;
        same_addr = (bus.addr_a == bus.addr_b);
        coll_d    = acc_a & acc_b & same_addr & (bus.we_a | bus.we_b);
        mask_a    = wr_a ? bus.be_a : '0;
        mask_b    = wr_b ? (bus.be_b & ~((same_addr & wr_a) ? bus.be_a : '0)) : '0;
        old_a     = mem[bus.addr_a];
        old_b     = mem[bus.addr_b];
        post_a    = old_a;
        post_b    = old_b;
        for (int i = 0; i < BE_W; i++) begin
            if (same_addr && mask_b[i]) post_a[8*i +: 8] = bus.wdata_b[8*i +: 8];
            if (mask_a[i])              post_a[8*i +: 8] = bus.wdata_a[8*i +: 8];
            if (mask_b[i])              post_b[8*i +: 8] = bus.wdata_b[8*i +: 8];
            if (same_addr && mask_a[i]) post_b[8*i +: 8] = bus.wdata_a[8*i +: 8];
        end
        // A reader never sees the other port's write; only its own write may be forwarded
        rdata1_a_d = (wr_a && RDW_MODE == 1) ? post_a : old_a;
        rdata1_b_d = (wr_b && RDW_MODE == 1) ? post_b : old_b;
    end

    // Array write: clear sweep, otherwise the per-lane merge of both ports
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr_q] <= CLEAR_VAL;
        end else begin
            for (int i = 0; i < BE_W; i++) begin
                if (mask_a[i]) mem[bus.addr_a][8*i +: 8] <= bus.wdata_a[8*i +: 8];
                if (mask_b[i]) mem[bus.addr_b][8*i +: 8] <= bus.wdata_b[8*i +: 8];
            end
        end
    end

    // First read stage plus collision pulse; rdata holds when the port is idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata1_a_q  <= '0;
            rdata1_b_q  <= '0;
            rvalid1_a_q <= 1'b0;
            rvalid1_b_q <= 1'b0;
            upd1_a_q    <= 1'b0;
            upd1_b_q    <= 1'b0;
            coll_q      <= 1'b0;
        end else begin
            if (acc_a) rdata1_a_q <= rdata1_a_d;
            if (acc_b) rdata1_b_q <= rdata1_b_d;
            rvalid1_a_q <= rd_a;
            rvalid1_b_q <= rd_b;
            upd1_a_q    <= acc_a;
            upd1_b_q    <= acc_b;
            coll_q      <= coll_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] rdata2_a_q, rdata2_b_q;
            logic              rvalid2_a_q, rvalid2_b_q;

            // Optional output stage; only refreshed when stage one carried new data
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rdata2_a_q  <= '0;
                    rdata2_b_q  <= '0;
                    rvalid2_a_q <= 1'b0;
                    rvalid2_b_q <= 1'b0;
                end else begin
                    if (upd1_a_q) rdata2_a_q <= rdata1_a_q;
                    if (upd1_b_q) rdata2_b_q <= rdata1_b_q;
                    rvalid2_a_q <= rvalid1_a_q;
                    rvalid2_b_q <= rvalid1_b_q;
                end
            end

            assign bus.rdata_a  = rdata2_a_q;
            assign bus.rdata_b  = rdata2_b_q;
            assign bus.rvalid_a = rvalid2_a_q;
            assign bus.rvalid_b = rvalid2_b_q;
        end else begin : g_no_out_reg
            logic unused_upd;
            assign unused_upd   = upd1_a_q ^ upd1_b_q;
            assign bus.rdata_a  = rdata1_a_q;
            assign bus.rdata_b  = rdata1_b_q;
            assign bus.rvalid_a = rvalid1_a_q;
            assign bus.rvalid_b = rvalid1_b_q;
        end
    endgenerate

    assign bus.init_busy = init_busy;
    assign bus.collision = coll_q;

`ifdef MP64_SRAM_COLL_CNT_EN
    logic [15:0] coll_cnt_q;

    // Saturating collision counter, updated on the same edge as the pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coll_cnt_q <= '0;
        end else if (coll_d && coll_cnt_q != 16'hFFFF) begin
            coll_cnt_q <= coll_cnt_q + 16'd1;
        end
    end

    assign coll_count = coll_cnt_q;
`endif
endmodule
